// File: rtl/alu_share_arbiter.sv
// Two-port round-robin front end sharing one 64-bit ALU; each port gets a
// single-entry result buffer with drain bypass.

module alu #(
    parameter int n = 64
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [3:0]   alu_ctrl,
    output logic [n-1:0] out,
    output logic         z
);
    always_comb begin
        out = '0;
        case (alu_ctrl)
            4'b0000: out = a & b;
            4'b0001: out = a | b;
            4'b0010: out = a + b;
            4'b0110: out = a + ~b + {{(n-1){1'b0}}, 1'b1};
            4'b0111: out = b;
            4'b1100: out = ~(a | b);
            default: out = '0;
        endcase
    end

    assign z = (out == '0);
endmodule

module alu_share_arbiter #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [3:0]   req0_ctrl,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [N-1:0] rsp0_out,
    output logic         rsp0_z,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req1_ctrl,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [N-1:0] rsp1_out,
    output logic         rsp1_z,
    output logic         busy
);
    logic         prio;
    logic         elig0, elig1;
    logic         grant0, grant1;
    logic [N-1:0] alu_a, alu_b, alu_out;
    logic [3:0]   alu_ctrl;
    logic         alu_z;

    // A full buffer counts as free when it drains this same cycle.
    assign elig0  = req0_valid && (!rsp0_valid || rsp0_ready);
    assign elig1  = req1_valid && (!rsp1_valid || rsp1_ready);
    assign grant0 = rst_n && elig0 && (!elig1 || !prio);
    assign grant1 = rst_n && elig1 && (!elig0 || prio);

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = rsp0_valid || rsp1_valid;

    always_comb begin
        alu_a    = req0_a;
        alu_b    = req0_b;
        alu_ctrl = req0_ctrl;
        if (grant1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_ctrl;
        end
    end

    alu #(.n(N)) u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .alu_ctrl (alu_ctrl),
        .out      (alu_out),
        .z        (alu_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio       <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_out   <= '0;
            rsp0_z     <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_out   <= '0;
            rsp1_z     <= 1'b0;
        end else begin
            // Pointer moves only under contention, to the loser.
            if (elig0 && elig1)
                prio <= grant0;

            if (grant0) begin
                rsp0_valid <= 1'b1;
                rsp0_out   <= alu_out;
                rsp0_z     <= alu_z;
            end else if (rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end

            if (grant1) begin
                rsp1_valid <= 1'b1;
                rsp1_out   <= alu_out;
                rsp1_z     <= alu_z;
            end else if (rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with hand-computed expected values.

module tb_alu_share_arbiter;
    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_PSB = 4'b0111;
    localparam logic [3:0] C_NOR = 4'b1100;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_z;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_z;
    logic [63:0] req0_a, req0_b, rsp0_out, req1_a, req1_b, rsp1_out;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.N(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_out   (rsp0_out),
        .rsp0_z     (rsp0_z),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_out   (rsp1_out),
        .rsp1_z     (rsp1_z),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic v, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b;
    endtask

    initial begin
        rst_n = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set0(1'b1, C_ADD, 64'd5, 64'd7);
        set1(1'b0, C_AND, 64'd0, 64'd0);
        tick();
        tick();
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp0_out", rsp0_out, 0);
        check("rst_req0_ready", req0_ready, 0);

        // Single request: ADD 5+7
        rst_n = 1'b1;
        #1;
        check("add_req0_ready", req0_ready, 1);
        tick();
        set0(1'b0, C_ADD, 64'd0, 64'd0);
        check("add_rsp0_valid", rsp0_valid, 1);
        check("add_rsp0_out", rsp0_out, 64'd12);
        check("add_rsp0_z", rsp0_z, 0);
        check("add_busy", busy, 1);

        // SUB to zero and wrap
        set1(1'b1, C_SUB, 64'h1234, 64'h1234);
        #1;
        check("sub0_req1_ready", req1_ready, 1);
        tick();
        check("sub0_out", rsp1_out, 0);
        check("sub0_z", rsp1_z, 1);
        set1(1'b1, C_SUB, 64'd0, 64'd1);
        #1;
        check("sub1_req1_ready", req1_ready, 1);
        tick();
        set1(1'b0, C_SUB, 64'd0, 64'd0);
        check("sub1_out", rsp1_out, ONES);
        check("sub1_z", rsp1_z, 0);
        tick();

        // Contention: grants alternate starting with port 0
        set0(1'b1, C_ADD, 64'd1, 64'd2);
        set1(1'b1, C_OR, 64'd8, 64'd1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_req0_ready", req0_ready, (i % 2 == 0));
            check("rr_req1_ready", req1_ready, (i % 2 == 1));
            if (i > 0) begin
                check("rr_rsp0_valid", rsp0_valid, (i % 2 == 1));
                check("rr_rsp1_valid", rsp1_valid, (i % 2 == 0));
            end
            tick();
        end
        set0(1'b0, C_ADD, 64'd0, 64'd0);
        set1(1'b0, C_OR, 64'd0, 64'd0);
        check("rr_rsp1_out", rsp1_out, 64'd9);
        check("rr_rsp0_out", rsp0_out, 64'd3);
        tick();

        // Backpressure on port 0
        rsp0_ready = 1'b0;
        set0(1'b1, C_AND, 64'hFF, 64'h0F);
        tick();
        check("bp_fill_out", rsp0_out, 64'h0F);
        set0(1'b1, C_AND, 64'hF0, 64'h3C);
        set1(1'b1, C_ADD, 64'd2, 64'd3);
        #1;
        check("bp_req0_ready", req0_ready, 0);
        check("bp_req1_ready", req1_ready, 1);
        tick();
        set1(1'b0, C_ADD, 64'd0, 64'd0);
        check("bp_hold_out", rsp0_out, 64'h0F);
        check("bp_rsp1_out", rsp1_out, 64'd5);
        check("bp_req0_ready2", req0_ready, 0);
        rsp0_ready = 1'b1;
        #1;
        check("bp_bypass_ready", req0_ready, 1);
        tick();
        set0(1'b0, C_AND, 64'd0, 64'd0);
        check("bp_rsp0_valid", rsp0_valid, 1);
        check("bp_rsp0_out", rsp0_out, 64'h30);
        check("bp_rsp0_z", rsp0_z, 0);

        // Pass-B and NOR
        set0(1'b1, C_PSB, 64'h5555, 64'hABCD);
        tick();
        check("passb_out", rsp0_out, 64'hABCD);
        set0(1'b1, C_NOR, 64'd0, 64'd0);
        tick();
        set0(1'b0, C_NOR, 64'd0, 64'd0);
        check("nor_out", rsp0_out, ONES);
        check("nor_z", rsp0_z, 0);
        tick();

        // Move pointer to port 1, then reset mid-operation
        set0(1'b1, C_ADD, 64'd5, 64'd7);
        set1(1'b1, C_ADD, 64'd1, 64'd1);
        #1;
        check("mr_pre_req0_ready", req0_ready, 1);
        tick();
        rsp0_ready = 1'b0;
        #1;
        check("mr_rsp0_valid", rsp0_valid, 1);
        check("mr_req1_ready", req1_ready, 1);
        rst_n = 1'b0;
        #1;
        check("mr_rst_rsp0_valid", rsp0_valid, 0);
        check("mr_rst_busy", busy, 0);
        check("mr_rst_req1_ready", req1_ready, 0);
        tick();
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        #1;
        check("mr_first_req0_ready", req0_ready, 1);
        check("mr_first_req1_ready", req1_ready, 0);
        tick();
        set0(1'b0, C_ADD, 64'd0, 64'd0);
        set1(1'b0, C_ADD, 64'd0, 64'd0);
        check("mr_rsp0_out", rsp0_out, 64'd12);
        check("mr_rsp1_valid", rsp1_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one instance of the team's 64-bit ALU between two requesters. Port 0 is the EX-stage issue path; port 1 is the address/branch-compare helper.
- Each requester drives a valid/ready operation handshake and receives its result through its own valid/ready response buffer, which holds one result.
- Round-robin arbitration guarantees that neither port starves. The block issues at most one ALU operation per clock.

Parameters:
- N, 64, operand and result width; passed to the ALU instance as n.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  port 0 operation valid
- req0_ready  output  1  port 0 operation accepted this cycle when valid and ready are both high
- req0_a  input  N  port 0 operand A
- req0_b  input  N  port 0 operand B
- req0_ctrl  input  4  port 0 ALU control code
- rsp0_valid  output  1  port 0 result held in buffer
- rsp0_ready  input  1  port 0 consumer takes the result
- rsp0_out  output  N  port 0 result
- rsp0_z  output  1  port 0 zero flag
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl, rsp1_valid, rsp1_ready, rsp1_out, rsp1_z: same directions, widths and meanings for port 1.
- busy  output  1  high when either response buffer is full

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp0_valid, rsp1_valid and busy drop to 0 immediately.
  - rsp*_out and rsp*_z clear to 0.
  - The priority pointer resets to port 0.
  - Any result in a buffer is discarded.
  - req*_ready is low while rst_n is low.
- Eligibility:
  - Port i is eligible when reqi_valid=1 and its buffer is free.
  - A buffer is free when rspi_valid=0, or when rspi_valid=1 and rspi_ready=1 in the same cycle (bypass on drain).
- Grant:
  - If one port is eligible, it is granted.
  - If both are eligible, the port named by the priority pointer is granted.
  - At most one grant is issued per cycle.
  - reqi_ready=1 only for the granted port. It is combinational from the valids, the rsp valid/ready signals and the pointer.
  - reqi_ready never depends combinationally on reqi_a, reqi_b or reqi_ctrl.
- Execution:
  - The granted port's a, b and ctrl are muxed into the single ALU combinationally.
  - At the same rising edge: ALU Out is stored into rspi_out, ALU Z into rspi_z, and rspi_valid is set to 1.
  - Latency: a request accepted in cycle k shows rspi_valid=1 in cycle k+1.
  - Throughput: one operation per clock in aggregate.
- ALU control codes passed through unchanged:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (A plus inverted B plus 1)
  - 0111 pass B
  - 1100 NOR
  - Other codes produce whatever the ALU outputs; the arbiter does no checking.
- Response:
  - rspi_valid clears on the edge where rspi_valid and rspi_ready are both high, unless a new grant to port i occurs that same cycle. In that case the buffer reloads and rspi_valid stays 1.
  - rspi_out and rspi_z stay stable while rspi_valid=1 and rspi_ready=0.
- Priority pointer:
  - Updates only on a cycle where both ports were eligible.
  - It then points to the port that was not granted.
  - A grant without contention leaves the pointer unchanged.
- busy = rsp0_valid OR rsp1_valid, registered-derived.
- Arithmetic: full-width modular; carry out is discarded; Z=1 exactly when the result is all zeros.
- A requester must hold its valid, a, b and ctrl stable until it is accepted. The arbiter does not register requests before grant.
- Reset asserted mid-operation drops every in-flight result. After rst_n rises, the first eligible cycle arbitrates with port 0 priority.

Test Plan:
- Reset and single request:
  - Stimulus: reset; then req0 ADD with a=5, b=7.
  - Required: req0_ready=1 in cycle 0; next cycle rsp0_valid=1, rsp0_out=12, rsp0_z=0, busy=1.
- SUB to zero:
  - Stimulus: req1 SUB with a=0x1234, b=0x1234.
  - Required: rsp1_out=0, rsp1_z=1.
  - Stimulus: req1 SUB with a=0, b=1.
  - Required: rsp1_out=0xFFFF_FFFF_FFFF_FFFF, z=0.
- Contention round-robin:
  - Stimulus: both ports valid every cycle, rsp ready tied high.
  - Required: grants alternate 0,1,0,1 starting with port 0 after reset; each port sees a result every other cycle.
- Backpressure:
  - Stimulus: rsp0_ready=0 with rsp0 full; req0 valid with AND a=0xF0, b=0x3C.
  - Required: req0_ready=0 and rsp0_out holds its value; port 1 is still granted freely.
  - Stimulus: raise rsp0_ready.
  - Required: req0 is granted that same cycle (bypass), rsp0_valid stays 1, and rsp0_out becomes 0x30 the next cycle.
- Pass-B and NOR:
  - Stimulus: ctrl 0111 with b=0xABCD.
  - Required: out=0xABCD.
  - Stimulus: ctrl 1100 with a=0, b=0.
  - Required: out is all ones, z=0.
- Mid-operation reset:
  - Stimulus: assert rst_n low asynchronously while rsp0_valid=1.
  - Required: rsp0_valid=0 immediately.
  - Stimulus: with both ports valid, release reset.
  - Required: port 0 is granted first.
